imm_issue_ctrl: RTL
===================

# imm_issue_ctrl

Decode-stage immediate issue controller. It accepts one instruction per cycle from fetch/decode over a valid/ready handshake. It selects the immediate field for the instruction format and widens it to 32 bits through the `sign_extend` datapath. It then presents the result, with its tag, to execute through a registered, two-entry skid-buffered output. It owns back-pressure, flush, and a stall-cycle performance counter for the immediate path.

## Interface
- `TAG_W`, 32: width of the pass-through tag (normally the PC).
- `CNT_W`, 16: width of the saturating stall counter.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: synchronous, active-low reset. It is sampled on the rising edge of `clk`.
- `in_valid`  in  1: upstream holds a valid instruction.
- `in_ready`  out  1: controller can accept this cycle.
- `in_inst`  in  32: raw instruction word.
- `in_fmt`  in  2: immediate format.
  - 0 = I: `inst[31:20]`.
  - 1 = S: `{inst[31:25], inst[11:7]}`.
  - 2 = Z: `inst[31:20]`, zero-extended.
  - 3 = U: `{inst[31:12], 12'b0}`.
- `in_tag`  in  `TAG_W`: carried unchanged with the immediate.
- `flush`  in  1: discard all held entries.
- `out_valid`  out  1: `out_imm`/`out_tag` valid.
- `out_ready`  in  1: downstream accepts this cycle.
- `out_imm`  out  32: expanded immediate.
- `out_tag`  out  `TAG_W`: tag of the presented entry.
- `stall_cnt`  out  `CNT_W`: number of cycles with `out_valid & ~out_ready`.

## Operation
- **Formats I/S:**
  - The 12-bit field goes through `sign_extend`.
  - Bit 11 is replicated into bits [31:12].
- **Format Z:** `{20'b0, field}`.
- **Format U:** upper 20 bits placed directly, low 12 bits zero. There is no extension.
- **Storage:**
  - Output register OUT (`out_valid`, `out_imm`, `out_tag`).
  - Skid register SKID (`skid_valid` + data).
- **State, derived from (`out_valid`, `skid_valid`):**
  - EMPTY = (0,0).
  - ONE = (1,0).
  - FULL = (1,1).
  - (0,1) is illegal and must never occur.
- **Handshakes:**
  - Accept = `in_valid & in_ready`.
  - Drain = `out_valid & out_ready`.
- **Transitions:**
  - EMPTY + accept → ONE (the new entry goes to OUT).
  - ONE + accept, no drain → FULL (the new entry goes to SKID).
  - ONE + accept + drain → ONE (OUT is reloaded with the new entry).
  - ONE + drain only → EMPTY.
  - FULL + drain → ONE (SKID moves to OUT). `in_ready` is 0 in FULL, so there is no accept.
- **Ordering:** strict FIFO. Entries are never reordered or duplicated.
- **`in_ready`:** registered, equal to `~skid_valid`. It has no combinational path from `out_ready`.
- **Data stability:** `out_imm`/`out_tag` are held stable while `out_valid & ~out_ready`.
- **Flush:**
  - OUT and SKID are cleared on the next edge.
  - Flush has priority over accept and drain in the same cycle. An instruction presented with `flush`=1 is dropped, and an output drain in that cycle still counts as taken downstream.
- **`stall_cnt`:**
  - Increments each cycle with `out_valid & ~out_ready`.
  - Saturates at 2^`CNT_W`-1.
  - Not cleared by flush; cleared only by reset.

## Timing
- **Latency:** 1 cycle. An instruction accepted at edge N shows on `out_*` after edge N (the same cycle `out_valid` rises). With a continuously ready consumer, back-to-back throughput is 1 per cycle.
- **Reset (`rst_n`=0 at an edge):** the following are 0 after that edge:
  - `out_valid`, `skid_valid`, `out_imm`, `out_tag`, `stall_cnt`.
  - `in_ready` = 1 after reset.
- **Reset mid-operation:** held entries are lost, with no partial output. Reset has priority over flush.
- **Boundaries:**
  - FULL with `out_ready`=0: hold indefinitely, `in_ready`=0.
  - Counter at max: holds value.
  - Flush in EMPTY: no effect.

## Structure
- **Shared package `pipe_pkg`:**
  - `IMM_FMT_I`=2'd0, `IMM_FMT_S`=2'd1, `IMM_FMT_Z`=2'd2, `IMM_FMT_U`=2'd3.
  - Immediate field width constant 12.
- **Sub-module:** instantiate the existing `sign_extend` once, on the selected 12-bit field, ahead of the format mux.
- **Skid logic:** kept in this module. No separate FIFO sub-module.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1, `stall_cnt`=0. No entry is captured.
- **Formats:** the required `out_imm` after 1 cycle:
  - I, inst 0xFFF00093 → 0xFFFFFFFF.
  - Z, same inst → 0x00000FFF.
  - S, 0x80000023 → 0xFFFFF800.
  - U, 0x12345037 → 0x12345000.
  - I, 0x7FF00013 → 0x000007FF.
- **Back-pressure:** send tags 1, 2, 3 back-to-back with `out_ready`=0 → `in_ready` drops after 2 accepts and tag 3 waits. Then raise `out_ready` → tags delivered in order 1, 2, 3, and `stall_cnt` equals the stalled cycles.
- **Simultaneous accept+drain in ONE:** stream 8 instructions with `out_ready`=1 → 8 outputs on consecutive cycles, `in_ready` stays 1.
- **Flush:** in FULL, assert `flush` together with `in_valid` (tag 9) → next cycle `out_valid`=0, `in_ready`=1, and tag 9 never appears.
- **Saturation:** with `CNT_W`=4, stall for 20 cycles → `stall_cnt`=15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared decode-pipe definitions.
//   imm_fmt_e   : immediate format selector carried on in_fmt.
//   buf_state_e : occupancy of the OUT/SKID pair, encoded as {out_valid, skid_valid}.
//   IMM_FIELD_W : width of the raw immediate field before widening.
package pipe_pkg;

  localparam int IMM_FIELD_W = 12;

  typedef enum logic [1:0] {
    IMM_FMT_I = 2'd0,
    IMM_FMT_S = 2'd1,
    IMM_FMT_Z = 2'd2,
    IMM_FMT_U = 2'd3
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_ILLEGAL = 2'b01,
    ST_ONE     = 2'b10,
    ST_FULL    = 2'b11
  } buf_state_e;

endpackage

// File: rtl/imm_issue_ctrl_if.sv
// Handshake bundle between fetch/decode, the immediate issue controller and execute.
//   in_*  : instruction side (valid/ready, raw word, format, tag).
//   out_* : execute side (valid/ready, expanded immediate, tag).
// Modports: master = environment (drives instructions, consumes results),
//           slave  = controller.
interface imm_issue_ctrl_if #(
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [1:0]       in_fmt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_imm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_inst, in_fmt, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_fmt, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );
endinterface

// File: rtl/sign_extend.sv
// Sign-extension datapath: replicates the MSB of din into the upper bits of dout.
//   din  : IN_W-bit field.
//   dout : OUT_W-bit sign-extended value.
module sign_extend #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);
  assign dout = {{(OUT_W - IN_W){din[IN_W-1]}}, din};
endmodule

// File: rtl/imm_issue_ctrl.sv
// Decode-stage immediate issue controller.
// Expands the immediate of each accepted instruction to 32 bits and issues it,
// with its tag, through a registered two-entry skid buffer (OUT + SKID).
//   clk, rst_n : clock, synchronous active-low reset.
//   bus        : instruction/result handshakes (slave side).
//   flush      : drop every held entry on the next edge.
//   stall_cnt  : saturating count of cycles with out_valid & ~out_ready.
module imm_issue_ctrl
  import pipe_pkg::*;
#(
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_issue_ctrl_if.slave  bus,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [IMM_FIELD_W-1:0] field;
  logic [31:0]            field_sext;
  entry_t                 new_entry;
  entry_t                 out_q;
  entry_t                 skid_q;
  logic                   out_valid_q;
  logic                   skid_valid_q;
  logic                   in_ready_q;
  logic                   accept;
  logic                   drain;
  buf_state_e             state;

  // The opcode bits never feed the immediate; folded here so they are visibly consumed.
  logic unused_opcode;
  assign unused_opcode = ^bus.in_inst[6:0];

  // S keeps its field split around rd; every other format reads inst[31:20].
  assign field = (imm_fmt_e'(bus.in_fmt) == IMM_FMT_S) ?
                 {bus.in_inst[31:25], bus.in_inst[11:7]} : bus.in_inst[31:20];

  sign_extend #(.IN_W(IMM_FIELD_W), .OUT_W(32)) u_sext (
    .din  (field),
    .dout (field_sext)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    new_entry.tag = bus.in_tag;
    new_entry.imm = field_sext;
    case (imm_fmt_e'(bus.in_fmt))
      IMM_FMT_Z: new_entry.imm = {20'b0, field};
      IMM_FMT_U: new_entry.imm = {bus.in_inst[31:12], 12'b0};
      default:   new_entry.imm = field_sext;
    endcase
  end

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;
  assign state  = buf_state_e'({out_valid_q, skid_valid_q});

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_q        <= '0;
      stall_cnt    <= '0;
    end else begin
      if (out_valid_q && !bus.out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;

      // Only the valid flags are cleared on flush; stale data behind a low valid is harmless.
      if (flush) begin
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (accept) begin
              out_q       <= new_entry;
              out_valid_q <= 1'b1;
            end
          end
          ST_ONE: begin
            if (accept && drain) begin
              out_q <= new_entry;
            end else if (accept) begin
              // NOTE: SKID data has no reset; skid_valid alone qualifies it.
              skid_q       <= new_entry;
              skid_valid_q <= 1'b1;
              in_ready_q   <= 1'b0;
            end else if (drain) begin
              out_valid_q <= 1'b0;
            end
          end
          ST_FULL: begin
            if (drain) begin
              out_q        <= skid_q;
              skid_valid_q <= 1'b0;
              in_ready_q   <= 1'b1;
            end
          end
          default: begin
            // Unreachable encoding: drop the orphaned skid entry and reopen the input.
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_q.imm;
  assign bus.out_tag   = out_q.tag;

endmodule
